rv32_mem: RTL
=============

# rv32_mem

Memory-access pipeline stage of the RV32 core, directly downstream of the execute stage and its ALU. It takes the ALU result as either a load/store effective address or a plain writeback value. It drives a single-outstanding-request data bus with byte-lane steering and write masks, and registers the writeback-bound result for the writeback stage. The execute stage is stalled while a bus access is in flight.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  execute-stage instruction valid.
- read_in  in  1  instruction is a load.
- write_in  in  1  instruction is a store.
- width_in  in  2  access width: byte 00, half 01, word 10 (11 illegal, treated as word).
- zero_extend_in  in  1  load is LBU/LHU.
- rd_in  in  5  destination register.
- rd_write_in  in  1  instruction writes rd.
- result_in  in  32  ALU result: address for loads/stores, else writeback value.
- rs2_value_in  in  32  store data.
- flush_in  in  1  kill the instruction currently offered on the *_in ports.
- stall_out  out  1  execute stage must hold its outputs.
- bus_address_out  out  32  word-aligned address ({result[31:2],2'b00}).
- bus_read_out  out  1  read request.
- bus_write_out  out  1  write request.
- bus_write_mask_out  out  4  byte enables, bit n = byte lane n.
- bus_write_value_out  out  32  lane-steered store data.
- bus_read_value_in  in  32  read data, valid with bus_ready_in.
- bus_ready_in  in  1  completes the outstanding request this cycle.
- valid_out  out  1  writeback-stage instruction valid.
- rd_out  out  5  destination register.
- rd_write_out  out  1  writeback enable.
- rd_value_out  out  32  writeback value.
- misaligned_out  out  1  the instruction in valid_out faulted on alignment.

## Operation
- FSM states: IDLE, BUSY. Reset value is IDLE.
- Reset values of outputs:
  - All bus_* outputs are 0.
  - valid_out, rd_write_out and misaligned_out are 0.
  - rd_out is 0 and rd_value_out is 0.
- IDLE with valid_in=1, flush_in=0, and neither read_in nor write_in: register rd_in, rd_write_in and result_in to the outputs, with valid_out=1. Stay in IDLE.
- IDLE with a valid, unflushed, aligned load or store:
  - Latch the address, the read or write strobe, the mask and the steered data into the bus registers.
  - Latch rd, width, zero_extend and addr[1:0] internally.
  - Go to BUSY, with valid_out=0 this edge.
- Alignment rules:
  - A halfword access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - A misaligned access issues no bus request and stays in IDLE.
  - It registers valid_out=1, misaligned_out=1, rd_write_out=0.
- Store steering:
  - Byte: data replicated to all 4 lanes, mask = 0001<<addr[1:0].
  - Half: data replicated to both halves, mask = 0011<<{addr[1],1'b0}.
  - Word: data unmodified, mask = 1111.
- Load alignment:
  - Select the byte at lane addr[1:0], or the halfword at lane addr[1].
  - Sign-extend unless zero_extend was set.
- BUSY: the bus outputs hold stable. On bus_ready_in=1:
  - Clear the bus strobes.
  - Register valid_out=1, and for loads rd_value_out = the aligned load data.
  - For stores, rd_write_out=0.
  - Return to IDLE.
- flush_in in IDLE drops the offered instruction (valid_out=0). flush_in in BUSY does not abort the bus access. The access completes, but valid_out stays 0 on completion.
- Asserting reset mid-BUSY immediately (asynchronously) drops the bus strobes and returns to IDLE. The in-flight access is abandoned.

## Timing
- stall_out is combinational: stall_out = (state==BUSY) && !bus_ready_in. Also stall_out = 1 in the IDLE cycle that accepts a load or store.
- Non-memory instruction: 1 cycle latency, valid_in to valid_out.
- Loads and stores: at least 2 cycles, plus the bus wait cycles.
- The bus request is asserted the cycle after acceptance.
- bus_ready_in is ignored in IDLE.
- With bus_ready_in=1 in the first BUSY cycle, valid_out rises 2 cycles after acceptance.
- Back-to-back accesses: the next instruction is accepted in the IDLE cycle after completion. There is at most one request outstanding.
- valid_out is a 1-cycle pulse per instruction. The writeback stage never stalls.

## Structure
- Shared header/package holds:
  - The width encodings as constants: RV32_MEM_WIDTH_BYTE/HALF/WORD.
  - The FSM state encoding.
- Sub-module rv32_mem_align: combinational store lane steering and mask generation, load byte/half extraction and extension, and the misalignment check.

## Test plan
- Non-memory: valid_in=1, result_in=0x12345678, rd_in=5 → next cycle valid_out=1, rd_out=5, rd_value_out=0x12345678, no bus strobe.
- Store byte: rs2=0x000000AB, addr 0x1003 → bus_address_out=0x1000, mask=1000, bus_write_value_out=0xABABABAB. Hold bus_ready_in low 3 cycles → stall_out high throughout and bus outputs stable.
- Load byte with sign extension: read_value=0x80FF7F01, addr 0x2002, byte, zero_extend=0 → rd_value_out=0xFFFFFFFF. Same with addr 0x2003 and zero_extend=1 → 0x00000080.
- Misaligned word load at 0x3002 → no bus request, valid_out=1, misaligned_out=1, rd_write_out=0, 1-cycle latency.
- Flush in BUSY: store in flight, flush_in=1 → write completes on bus_ready_in, valid_out stays 0.
- Reset mid-BUSY: assert reset while bus_read_out=1 → bus_read_out drops before the next edge. After release, a fresh load completes normally.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rv32_mem_pkg                                                  |
// | Purpose  : Shared definitions for the RV32 memory-access stage: access   |
// |            width encodings and the stage FSM state encoding.             |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package rv32_mem_pkg;

   // Access width encodings as driven by the execute stage. 2'b11 is
   // illegal and is handled everywhere as a word access.
   localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'b00;
   localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'b01;
   localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'b10;

   typedef enum logic [0:0] {
      RV32_MEM_IDLE = 1'b0,
      RV32_MEM_BUSY = 1'b1
   } rv32_mem_state_t;

endpackage : rv32_mem_pkg
`default_nettype wire

// File: rtl/rv32_mem_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rv32_mem_align                                                |
// | Purpose  : Combinational byte-lane logic for the memory stage.           |
// |            Store side: lane steering, byte-enable mask, alignment check. |
// |            Load side : byte/half extraction and sign/zero extension.     |
// | Ports    : st_width, st_addr_lo, st_data   -> st_mask, st_value,         |
// |                                               misaligned                 |
// |            ld_width, ld_addr_lo, ld_zero_extend, ld_data -> ld_value     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rv32_mem_align
   import rv32_mem_pkg::*;
(
   input  logic [1:0]  st_width,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_mask,
   output logic [31:0] st_value,
   output logic        misaligned,
   input  logic [1:0]  ld_width,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_zero_extend,
   input  logic [31:0] ld_data,
   output logic [31:0] ld_value
);

   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic        w_ld_sign;

   // Store steering: narrow data is replicated across lanes so the mask
   // alone selects which bytes memory actually updates.
   always_comb begin
      st_mask    = 4'b1111;
      st_value   = st_data;
      misaligned = 1'b0;
      case (st_width)
         RV32_MEM_WIDTH_BYTE: begin
            st_mask  = 4'b0001 << st_addr_lo;
            st_value = {4{st_data[7:0]}};
         end
         RV32_MEM_WIDTH_HALF: begin
            st_mask    = 4'b0011 << {st_addr_lo[1], 1'b0};
            st_value   = {2{st_data[15:0]}};
            misaligned = st_addr_lo[0];
         end
         default: begin
            misaligned = |st_addr_lo;
         end
      endcase
   end

   // Load extraction uses the width/offset latched at acceptance, since the
   // read data only arrives after the execute stage has moved on.
   always_comb begin
      case (ld_addr_lo)
         2'b00:   w_ld_byte = ld_data[7:0];
         2'b01:   w_ld_byte = ld_data[15:8];
         2'b10:   w_ld_byte = ld_data[23:16];
         default: w_ld_byte = ld_data[31:24];
      endcase
      w_ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
      w_ld_sign = 1'b0;
      case (ld_width)
         RV32_MEM_WIDTH_BYTE: begin
            w_ld_sign = w_ld_byte[7] & ~ld_zero_extend;
            ld_value  = {{24{w_ld_sign}}, w_ld_byte};
         end
         RV32_MEM_WIDTH_HALF: begin
            w_ld_sign = w_ld_half[15] & ~ld_zero_extend;
            ld_value  = {{16{w_ld_sign}}, w_ld_half};
         end
         default: begin
            ld_value = ld_data;
         end
      endcase
   end

endmodule : rv32_mem_align
`default_nettype wire

// File: rtl/rv32_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rv32_mem                                                      |
// | Purpose  : RV32 memory-access pipeline stage. Passes non-memory results  |
// |            through in one cycle; issues single-outstanding load/store    |
// |            requests on the data bus and stalls execute while in flight. |
// | Ports    : clk, reset (async, active-high)                               |
// |            execute side : valid_in, read_in, write_in, width_in,         |
// |                           zero_extend_in, rd_in, rd_write_in, result_in, |
// |                           rs2_value_in, flush_in, stall_out              |
// |            data bus     : bus_address_out, bus_read_out, bus_write_out,  |
// |                           bus_write_mask_out, bus_write_value_out,       |
// |                           bus_read_value_in, bus_ready_in                |
// |            writeback    : valid_out, rd_out, rd_write_out, rd_value_out, |
// |                           misaligned_out                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rv32_mem
   import rv32_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        read_in,
   input  logic        write_in,
   input  logic [1:0]  width_in,
   input  logic        zero_extend_in,
   input  logic [4:0]  rd_in,
   input  logic        rd_write_in,
   input  logic [31:0] result_in,
   input  logic [31:0] rs2_value_in,
   input  logic        flush_in,
   output logic        stall_out,
   output logic [31:0] bus_address_out,
   output logic        bus_read_out,
   output logic        bus_write_out,
   output logic [3:0]  bus_write_mask_out,
   output logic [31:0] bus_write_value_out,
   input  logic [31:0] bus_read_value_in,
   input  logic        bus_ready_in,
   output logic        valid_out,
   output logic [4:0]  rd_out,
   output logic        rd_write_out,
   output logic [31:0] rd_value_out,
   output logic        misaligned_out
);

   rv32_mem_state_t r_state;

   // Context of the in-flight access, captured at acceptance.
   logic [4:0]  r_rd;
   logic        r_rd_write;
   logic [1:0]  r_width;
   logic        r_zero_extend;
   logic [1:0]  r_addr_lo;
   logic        r_is_load;
   logic        r_killed;

   logic [3:0]  w_st_mask;
   logic [31:0] w_st_value;
   logic [31:0] w_ld_value;
   logic        w_misaligned;
   logic        w_is_mem;
   logic        w_is_store;
   logic        w_offer;
   logic        w_accept_mem;
   logic        w_killed;

   // A request with both strobes set is handled as a load.
   assign w_is_mem     = read_in | write_in;
   assign w_is_store   = write_in & ~read_in;
   assign w_offer      = valid_in & ~flush_in;
   assign w_accept_mem = (r_state == RV32_MEM_IDLE) & w_offer & w_is_mem & ~w_misaligned;

   // Stall covers the accepting cycle too, so execute never presents a new
   // instruction into the cycle the bus request goes out.
   assign stall_out = w_accept_mem | ((r_state == RV32_MEM_BUSY) & ~bus_ready_in);

   // A flush seen at any point during BUSY, including the completing cycle,
   // suppresses the writeback pulse but never the bus access itself.
   assign w_killed = r_killed | flush_in;

   rv32_mem_align u_align (
      .st_width       (width_in),
      .st_addr_lo     (result_in[1:0]),
      .st_data        (rs2_value_in),
      .st_mask        (w_st_mask),
      .st_value       (w_st_value),
      .misaligned     (w_misaligned),
      .ld_width       (r_width),
      .ld_addr_lo     (r_addr_lo),
      .ld_zero_extend (r_zero_extend),
      .ld_data        (bus_read_value_in),
      .ld_value       (w_ld_value)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state             <= RV32_MEM_IDLE;
         r_rd                <= 5'd0;
         r_rd_write          <= 1'b0;
         r_width             <= RV32_MEM_WIDTH_BYTE;
         r_zero_extend       <= 1'b0;
         r_addr_lo           <= 2'b00;
         r_is_load           <= 1'b0;
         r_killed            <= 1'b0;
         bus_address_out     <= 32'd0;
         bus_read_out        <= 1'b0;
         bus_write_out       <= 1'b0;
         bus_write_mask_out  <= 4'd0;
         bus_write_value_out <= 32'd0;
         valid_out           <= 1'b0;
         rd_out              <= 5'd0;
         rd_write_out        <= 1'b0;
         rd_value_out        <= 32'd0;
         misaligned_out      <= 1'b0;
      end else begin
         // Writeback outputs are single-cycle pulses.
         valid_out      <= 1'b0;
         misaligned_out <= 1'b0;
         case (r_state)
            RV32_MEM_IDLE: begin
               if (w_offer) begin
                  if (!w_is_mem) begin
                     valid_out    <= 1'b1;
                     rd_out       <= rd_in;
                     rd_write_out <= rd_write_in;
                     rd_value_out <= result_in;
                  end else if (w_misaligned) begin
                     // Faulting address is kept on rd_value_out for the
                     // trap logic downstream.
                     valid_out      <= 1'b1;
                     misaligned_out <= 1'b1;
                     rd_out         <= rd_in;
                     rd_write_out   <= 1'b0;
                     rd_value_out   <= result_in;
                  end else begin
                     bus_address_out     <= {result_in[31:2], 2'b00};
                     bus_read_out        <= read_in;
                     bus_write_out       <= w_is_store;
                     bus_write_mask_out  <= w_is_store ? w_st_mask : 4'b0000;
                     bus_write_value_out <= w_st_value;
                     r_rd                <= rd_in;
                     r_rd_write          <= rd_write_in;
                     r_width             <= width_in;
                     r_zero_extend       <= zero_extend_in;
                     r_addr_lo           <= result_in[1:0];
                     r_is_load           <= read_in;
                     r_killed            <= 1'b0;
                     r_state             <= RV32_MEM_BUSY;
                  end
               end
            end
            RV32_MEM_BUSY: begin
               if (flush_in) begin
                  r_killed <= 1'b1;
               end
               if (bus_ready_in) begin
                  bus_read_out  <= 1'b0;
                  bus_write_out <= 1'b0;
                  valid_out     <= ~w_killed;
                  rd_out        <= r_rd;
                  rd_write_out  <= r_is_load & r_rd_write;
                  if (r_is_load) begin
                     rd_value_out <= w_ld_value;
                  end
                  r_state <= RV32_MEM_IDLE;
               end
            end
            default: begin
               r_state <= RV32_MEM_IDLE;
            end
         endcase
      end
   end

endmodule : rv32_mem
`default_nettype wire
